// File: rtl/apb_timer.sv
// APB down-counting timer: CTRL/LOAD/COUNT/STATUS registers,
// 8-bit prescaler, one-shot or auto-reload, level interrupt.
module apb_timer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [2:0]              PPROT,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    IRQ
);

  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [2:0]    wcnt;
  logic          en;
  logic          reload;
  logic          ie;
  logic          status;
  logic          irq_q;
  logic [7:0]    prescale;
  logic [7:0]    pcnt;
  logic [DW-1:0] load;
  logic [DW-1:0] count;

  logic          active;
  logic          ready;
  logic          bad_addr;
  logic          err;
  logic          wr_ok;
  logic          sel_ctrl;
  logic          sel_load;
  logic          sel_count;
  logic          sel_stat;
  logic          w_en;
  logic          w_reload;
  logic          w_ie;
  logic [7:0]    w_pre;
  logic          w1c;
  logic          tick;
  logic          expire;
  logic [DW-1:0] wmask;
  logic [DW-1:0] load_new;
  logic [DW-1:0] ctrl_rd;
  logic [DW-1:0] rd_mux;
  logic          unused_ok;

  assign unused_ok = ^{PPROT, PADDR};

  assign active    = PSEL & PENABLE;
  assign ready     = active & (wcnt == WS) & ~PRESET;
  assign sel_ctrl  = PADDR[3:2] == 2'd0;
  assign sel_load  = PADDR[3:2] == 2'd1;
  assign sel_count = PADDR[3:2] == 2'd2;
  assign sel_stat  = PADDR[3:2] == 2'd3;
  assign bad_addr  = PADDR[1:0] != 2'b00;
  assign err       = ready & (bad_addr | (PWRITE & sel_count));
  assign wr_ok     = ready & PWRITE & ~err;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DW / 8; i++) begin
      wmask[i*8 +: 8] = {8{PSTRB[i]}};
    end
  end

  assign load_new = (load & ~wmask) | (PWDATA & wmask);
  assign w_en     = PSTRB[0] ? PWDATA[0] : en;
  assign w_reload = PSTRB[0] ? PWDATA[1] : reload;
  assign w_ie     = PSTRB[0] ? PWDATA[2] : ie;
  assign w_pre    = PSTRB[1] ? PWDATA[15:8] : prescale;
  assign w1c      = wr_ok & sel_stat & PSTRB[0] & PWDATA[0];

  assign tick   = en & (pcnt == prescale);
  assign expire = tick & (count == '0);

  always_comb begin
    ctrl_rd       = '0;
    ctrl_rd[0]    = en;
    ctrl_rd[1]    = reload;
    ctrl_rd[2]    = ie;
    ctrl_rd[15:8] = prescale;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl:  rd_mux = ctrl_rd;
      sel_load:  rd_mux = load;
      sel_count: rd_mux = count;
      sel_stat:  rd_mux[0] = status;
      default:   rd_mux = '0;
    endcase
  end

  assign PREADY  = ready;
  assign PSLVERR = err;
  assign PRDATA  = (ready & ~PWRITE & ~bad_addr) ? rd_mux : '0;
  assign IRQ     = irq_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wcnt     <= '0;
      en       <= 1'b0;
      reload   <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
      load     <= '0;
      count    <= '0;
      status   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (!active) begin
        wcnt <= '0;
      end else if (wcnt < WS) begin
        wcnt <= wcnt + 3'd1;
      end

      if (!en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 8'd1;
      end

      // A LOAD write overrides whatever the tick would do to COUNT
      if (wr_ok && sel_load) begin
        load  <= load_new;
        count <= load_new;
      end else if (tick) begin
        if (count != '0) begin
          count <= count - DW'(1);
        end else if (reload) begin
          count <= load;
        end
      end

      if (wr_ok && sel_ctrl) begin
        en       <= w_en;
        reload   <= w_reload;
        ie       <= w_ie;
        prescale <= w_pre;
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      if (expire) begin
        status <= 1'b1;
      end else if (w1c) begin
        status <= 1'b0;
      end

      irq_q <= status & ie;
    end
  end

endmodule
